// File: rtl/framebuffer_scheduler.sv
// -----------------------------------------------------------------------------
// framebuffer_scheduler
//
// Double-buffered framebuffer controller. The output path reads the buffer
// selected by front_sel. The renderer draws into the other buffer, called the
// back buffer, which is always ~front_sel.
//
// Each frame moves through three states:
//   CLEAR     : writes CLEAR_COLOR to every back-buffer pixel, one pixel per
//               cycle, scanning x first and then y.
//   DRAW      : forwards accepted renderer writes to the write port.
//   WAIT_SWAP : the renderer has finished; waits for new_frame, then swaps.
//
// Ports
//   Clk, Reset_n        : clock; asynchronous active-low reset
//   new_frame           : one-cycle frame-boundary pulse from the VGA path
//   frame_done          : renderer has finished drawing the back buffer
//   draw_req/x/y/color  : renderer pixel write request
//   draw_ack            : combinational; the request is accepted this cycle
//   wr_en/buf/x/y/color : registered framebuffer write port
//   front_sel           : buffer index the output path reads
//   clearing            : high while in CLEAR
//   frame_start         : one-cycle pulse after the last clear write lands
//   dropped_frames      : saturating count of new_frame pulses that did not
//                         cause a swap
// -----------------------------------------------------------------------------
module framebuffer_scheduler #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COLOR_BITS  = 3,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  new_frame,
    input  logic                  frame_done,
    input  logic                  draw_req,
    input  logic [9:0]            draw_x,
    input  logic [8:0]            draw_y,
    input  logic [COLOR_BITS-1:0] draw_color,
    output logic                  draw_ack,
    output logic                  wr_en,
    output logic                  wr_buf,
    output logic [9:0]            wr_x,
    output logic [8:0]            wr_y,
    output logic [COLOR_BITS-1:0] wr_color,
    output logic                  front_sel,
    output logic                  clearing,
    output logic                  frame_start,
    output logic [7:0]            dropped_frames
);

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_DRAW      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [9:0]            X_LAST  = 10'(WIDTH - 1);
    localparam logic [8:0]            Y_LAST  = 9'(HEIGHT - 1);
    localparam logic [10:0]           X_LIMIT = 11'(WIDTH);
    localparam logic [9:0]            Y_LIMIT = 10'(HEIGHT);
    localparam logic [COLOR_BITS-1:0] CLR_C   = COLOR_BITS'(CLEAR_COLOR);

    state_t                state_q, state_d;
    logic [9:0]            clr_x_q, clr_x_d;
    logic [8:0]            clr_y_q, clr_y_d;
    logic                  front_sel_q, front_sel_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_buf_q, wr_buf_d;
    logic [9:0]            wr_x_q, wr_x_d;
    logic [8:0]            wr_y_q, wr_y_d;
    logic [COLOR_BITS-1:0] wr_color_q, wr_color_d;
    logic                  clear_done_q, clear_done_d;
    logic                  frame_start_q, frame_start_d;
    logic [7:0]            dropped_q, dropped_d;

    logic back_sel;
    logic draw_in_range;
    logic do_swap;
    logic do_drop;

    assign back_sel      = ~front_sel_q;
    assign draw_in_range = ({1'b0, draw_x} < X_LIMIT) && ({1'b0, draw_y} < Y_LIMIT);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        clr_x_d       = clr_x_q;
        clr_y_d       = clr_y_q;
        front_sel_d   = front_sel_q;
        wr_en_d       = 1'b0;
        wr_buf_d      = wr_buf_q;
        wr_x_d        = wr_x_q;
        wr_y_d        = wr_y_q;
        wr_color_d    = wr_color_q;
        clear_done_d  = 1'b0;
        // frame_start trails the last clear write by one cycle. That write
        // has landed on the write port by the time drawing is announced.
        frame_start_d = clear_done_q;
        dropped_d     = dropped_q;
        draw_ack      = 1'b0;
        do_swap       = 1'b0;
        do_drop       = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                wr_en_d    = 1'b1;
                wr_buf_d   = back_sel;
                wr_x_d     = clr_x_q;
                wr_y_d     = clr_y_q;
                wr_color_d = CLR_C;
                if (clr_x_q == X_LAST) begin
                    clr_x_d = '0;
                    if (clr_y_q == Y_LAST) begin
                        clr_y_d      = '0;
                        clear_done_d = 1'b1;
                        state_d      = ST_DRAW;
                    end else begin
                        clr_y_d = clr_y_q + 9'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 10'd1;
                end
                do_drop = new_frame;
            end

            ST_DRAW: begin
                draw_ack = draw_req;
                // Out-of-range requests are acknowledged so the renderer
                // moves on, but they never reach the write port.
                if (draw_req && draw_in_range) begin
                    wr_en_d    = 1'b1;
                    wr_buf_d   = back_sel;
                    wr_x_d     = draw_x;
                    wr_y_d     = draw_y;
                    wr_color_d = draw_color;
                end
                if (frame_done) begin
                    if (new_frame) do_swap = 1'b1;
                    else           state_d = ST_WAIT_SWAP;
                end else begin
                    do_drop = new_frame;
                end
            end

            ST_WAIT_SWAP: begin
                do_swap = new_frame;
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (do_swap) begin
            front_sel_d = ~front_sel_q;
            state_d     = ST_CLEAR;
            clr_x_d     = '0;
            clr_y_d     = '0;
        end

        if (do_drop && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_CLEAR;
            clr_x_q       <= '0;
            clr_y_q       <= '0;
            front_sel_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_buf_q      <= 1'b0;
            wr_x_q        <= '0;
            wr_y_q        <= '0;
            wr_color_q    <= '0;
            clear_done_q  <= 1'b0;
            frame_start_q <= 1'b0;
            dropped_q     <= '0;
        end else begin
            state_q       <= state_d;
            clr_x_q       <= clr_x_d;
            clr_y_q       <= clr_y_d;
            front_sel_q   <= front_sel_d;
            wr_en_q       <= wr_en_d;
            wr_buf_q      <= wr_buf_d;
            wr_x_q        <= wr_x_d;
            wr_y_q        <= wr_y_d;
            wr_color_q    <= wr_color_d;
            clear_done_q  <= clear_done_d;
            frame_start_q <= frame_start_d;
            dropped_q     <= dropped_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_buf         = wr_buf_q;
    assign wr_x           = wr_x_q;
    assign wr_y           = wr_y_q;
    assign wr_color       = wr_color_q;
    assign front_sel      = front_sel_q;
    assign clearing       = (state_q == ST_CLEAR);
    assign frame_start    = frame_start_q;
    assign dropped_frames = dropped_q;

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_scheduler
//
// Directed bench for framebuffer_scheduler on a 4x2 frame. Renderer writes in
// DRAW are applied from a table of {inputs, expected outputs} records. The
// clear, swap, drop and reset corner cases are written out as short sequences.
// -----------------------------------------------------------------------------
module tb_framebuffer_scheduler;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CB = 3;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          new_frame;
    logic          frame_done;
    logic          draw_req;
    logic [9:0]    draw_x;
    logic [8:0]    draw_y;
    logic [CB-1:0] draw_color;
    logic          draw_ack;
    logic          wr_en;
    logic          wr_buf;
    logic [9:0]    wr_x;
    logic [8:0]    wr_y;
    logic [CB-1:0] wr_color;
    logic          front_sel;
    logic          clearing;
    logic          frame_start;
    logic [7:0]    dropped_frames;

    int n_checks = 0;
    int n_errors = 0;

    framebuffer_scheduler #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .COLOR_BITS (CB),
        .CLEAR_COLOR(0)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .new_frame     (new_frame),
        .frame_done    (frame_done),
        .draw_req      (draw_req),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .draw_color    (draw_color),
        .draw_ack      (draw_ack),
        .wr_en         (wr_en),
        .wr_buf        (wr_buf),
        .wr_x          (wr_x),
        .wr_y          (wr_y),
        .wr_color      (wr_color),
        .front_sel     (front_sel),
        .clearing      (clearing),
        .frame_start   (frame_start),
        .dropped_frames(dropped_frames)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          req;
        logic [9:0]    x;
        logic [8:0]    y;
        logic [CB-1:0] color;
        logic          exp_ack;
        logic          exp_en;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so that outputs are sampled
    // away from the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Runs a full 8-pixel clear into exp_buf, then checks the frame_start
    // pulse. pulse_at >= 0 raises new_frame in the cycle before that pixel.
    task automatic clear_seq(input logic exp_buf, input int pulse_at);
        for (int i = 0; i < W * H; i++) begin
            new_frame = (i == pulse_at);
            tick();
            new_frame = 1'b0;
            check($sformatf("clr%0d wr_en", i), 32'(wr_en), 32'd1);
            check($sformatf("clr%0d wr_buf", i), 32'(wr_buf), 32'(exp_buf));
            check($sformatf("clr%0d wr_x", i), 32'(wr_x), 32'(i % W));
            check($sformatf("clr%0d wr_y", i), 32'(wr_y), 32'(i / W));
            check($sformatf("clr%0d wr_color", i), 32'(wr_color), 32'd0);
            check($sformatf("clr%0d frame_start", i), 32'(frame_start), 32'd0);
        end
        check("clear end clearing", 32'(clearing), 32'd0);
        tick();
        check("frame_start pulse", 32'(frame_start), 32'd1);
        check("no write after clear", 32'(wr_en), 32'd0);
        tick();
        check("frame_start low again", 32'(frame_start), 32'd0);
    endtask

    initial begin
        // The table is filled before any stimulus is applied.
        vecs[0] = '{req: 1'b1, x: 10'd2, y: 9'd1, color: 3'd5, exp_ack: 1'b1, exp_en: 1'b1};
        vecs[1] = '{req: 1'b1, x: 10'd4, y: 9'd0, color: 3'd3, exp_ack: 1'b1, exp_en: 1'b0};
        vecs[2] = '{req: 1'b1, x: 10'd0, y: 9'd2, color: 3'd1, exp_ack: 1'b1, exp_en: 1'b0};
        vecs[3] = '{req: 1'b1, x: 10'd3, y: 9'd1, color: 3'd7, exp_ack: 1'b1, exp_en: 1'b1};
        vecs[4] = '{req: 1'b0, x: 10'd1, y: 9'd0, color: 3'd6, exp_ack: 1'b0, exp_en: 1'b0};
        vecs[5] = '{req: 1'b1, x: 10'd0, y: 9'd0, color: 3'd2, exp_ack: 1'b1, exp_en: 1'b1};

        Reset_n    = 1'b0;
        new_frame  = 1'b0;
        frame_done = 1'b0;
        draw_req   = 1'b1;
        draw_x     = '0;
        draw_y     = '0;
        draw_color = '0;

        // Reset state. draw_ack must stay low even while draw_req is high.
        tick();
        tick();
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst wr_buf", 32'(wr_buf), 32'd0);
        check("rst wr_x", 32'(wr_x), 32'd0);
        check("rst front_sel", 32'(front_sel), 32'd0);
        check("rst frame_start", 32'(frame_start), 32'd0);
        check("rst dropped", 32'(dropped_frames), 32'd0);
        check("rst draw_ack", 32'(draw_ack), 32'd0);
        check("rst clearing", 32'(clearing), 32'd1);
        draw_req = 1'b0;

        // After reset is released, the first clear goes to buffer 1.
        Reset_n = 1'b1;
        clear_seq(1'b1, -1);

        // Renderer writes in DRAW.
        for (int i = 0; i < 6; i++) begin
            draw_req   = vecs[i].req;
            draw_x     = vecs[i].x;
            draw_y     = vecs[i].y;
            draw_color = vecs[i].color;
            #1;
            check($sformatf("vec%0d draw_ack", i), 32'(draw_ack), 32'(vecs[i].exp_ack));
            tick();
            check($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                check($sformatf("vec%0d wr_buf", i), 32'(wr_buf), 32'd1);
                check($sformatf("vec%0d wr_x", i), 32'(wr_x), 32'(vecs[i].x));
                check($sformatf("vec%0d wr_y", i), 32'(wr_y), 32'(vecs[i].y));
                check($sformatf("vec%0d wr_color", i), 32'(wr_color), 32'(vecs[i].color));
            end
        end
        draw_req = 1'b0;

        // new_frame in DRAW without frame_done counts as a dropped frame.
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        check("drop in draw count", 32'(dropped_frames), 32'd1);
        check("drop in draw front_sel", 32'(front_sel), 32'd0);
        check("drop in draw stays", 32'(clearing), 32'd0);

        // new_frame and frame_done in the same cycle swap immediately.
        new_frame  = 1'b1;
        frame_done = 1'b1;
        tick();
        new_frame  = 1'b0;
        frame_done = 1'b0;
        check("simul swap front_sel", 32'(front_sel), 32'd1);
        check("simul swap dropped", 32'(dropped_frames), 32'd1);
        check("simul swap clearing", 32'(clearing), 32'd1);
        check("simul swap wr_en", 32'(wr_en), 32'd0);
        clear_seq(1'b0, -1);

        // frame_done, then WAIT_SWAP; new_frame arrives 3 cycles later.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        draw_req   = 1'b1;
        draw_x     = 10'd1;
        draw_y     = 9'd1;
        #1;
        check("wait draw_ack", 32'(draw_ack), 32'd0);
        tick();
        check("wait no write", 32'(wr_en), 32'd0);
        draw_req   = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        new_frame  = 1'b1;
        #1;
        check("pre swap front_sel", 32'(front_sel), 32'd1);
        tick();
        new_frame = 1'b0;
        check("swap front_sel", 32'(front_sel), 32'd0);
        check("swap clearing", 32'(clearing), 32'd1);
        // A new_frame during this clear is dropped.
        clear_seq(1'b1, 3);
        check("drop in clear count", 32'(dropped_frames), 32'd2);
        check("drop in clear front_sel", 32'(front_sel), 32'd0);

        // Swap, then assert reset partway through the clear.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        new_frame  = 1'b1;
        tick();
        new_frame = 1'b0;
        check("pre reset front_sel", 32'(front_sel), 32'd1);
        tick();
        tick();
        tick();
        check("mid clear wr_en", 32'(wr_en), 32'd1);
        check("mid clear wr_x", 32'(wr_x), 32'd2);
        Reset_n = 1'b0;
        #1;
        check("async rst wr_en", 32'(wr_en), 32'd0);
        check("async rst front_sel", 32'(front_sel), 32'd0);
        check("async rst dropped", 32'(dropped_frames), 32'd0);
        check("async rst wr_x", 32'(wr_x), 32'd0);
        check("async rst wr_buf", 32'(wr_buf), 32'd0);
        tick();
        check("held rst wr_en", 32'(wr_en), 32'd0);

        // The clear restarts at (0,0) into buffer 1 after reset is released.
        Reset_n = 1'b1;
        clear_seq(1'b1, -1);

        // Dropped-frame counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            new_frame = 1'b1;
            tick();
            new_frame = 1'b0;
            tick();
        end
        check("sat dropped", 32'(dropped_frames), 32'd255);
        check("sat front_sel", 32'(front_sel), 32'd0);
        check("sat still draw", 32'(clearing), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
